// File: rtl/conv_window_g_pkg.sv
// conv_pkg: shared widths, frame defaults and FSM encoding for the sliding-window generator
package conv_pkg;
  localparam int M_DEF     = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int NPASS_DEF = 8;
  localparam int GAP_DEF   = 4;
  typedef enum logic [1:0] {S_RUN, S_FIN, S_GAP} state_t;
endpackage

// File: rtl/conv_window_g_if.sv
// conv_window_g_if: pixel stream in, 3x3 window and pass status out
//   slave  (window generator): takes pix_valid/pix_data, drives pix_ready, window, pass status
//   master (pixel source/window sink): the opposite directions
interface conv_window_g_if import conv_pkg::*; #(parameter int M = M_DEF) ();
  logic         pix_valid;
  logic [M-1:0] pix_data;
  logic         pix_ready;
  logic         win_valid;
  logic [M-1:0] P00, P01, P02, P03, P04, P05, P06, P07, P08;
  logic         fmap_finish;
  logic [7:0]   pass_count;
  logic         all_done;
  modport slave (
    input  pix_valid, pix_data,
    output pix_ready, win_valid, P00, P01, P02, P03, P04, P05, P06, P07, P08,
    output fmap_finish, pass_count, all_done
  );
  modport master (
    output pix_valid, pix_data,
    input  pix_ready, win_valid, P00, P01, P02, P03, P04, P05, P06, P07, P08,
    input  fmap_finish, pass_count, all_done
  );
endinterface

// File: rtl/conv_window_g_line_buffer.sv
// line_buffer: DEPTH-stage enabled delay line; dout is the value written DEPTH enables ago
//   clk  : clock
//   en   : advance one stage
//   din  : value entering the line
//   dout : oldest value, valid before the enabling edge
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv_window_g.sv
// conv_window_g: raster-scan 3x3 sliding-window generator with per-pass finish pulse and input gap
//   clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : pixel stream (pix_valid/pix_data/pix_ready), window P00..P08 with win_valid,
//           fmap_finish, pass_count, all_done
module conv_window_g import conv_pkg::*; #(
  parameter int M     = M_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int NPASS = NPASS_DEF,
  parameter int GAP   = GAP_DEF
) (
  input logic           clk,
  input logic           Rst_n,
  conv_window_g_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = $clog2(GAP + 1);
  state_t         state, state_nx;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [GW-1:0]  gcnt;
  logic [7:0]     pass_cnt;
  logic [M-1:0]   win [9];
  logic [M-1:0]   l1, l2;
  logic           win_vld, ready, fin, done, xfer, col_last, row_last;
  assign col_last = col == CW'(IMG_W - 1);
  assign row_last = row == RW'(IMG_H - 1);
  assign xfer     = bus.pix_valid & ready;
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    fin      = 1'b0;
    done     = 1'b0;
    case (state)
      S_RUN: begin
        ready = 1'b1;
        if (bus.pix_valid && col_last && row_last) state_nx = S_FIN;
      end
      S_FIN: begin
        fin      = 1'b1;
        done     = pass_cnt == 8'(NPASS - 1);
        state_nx = S_GAP;
      end
      S_GAP: state_nx = gcnt == GW'(GAP - 1) ? S_RUN : S_GAP;
      default: state_nx = S_RUN;
    endcase
  end
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      state    <= S_RUN;
      col      <= '0;
      row      <= '0;
      gcnt     <= '0;
      pass_cnt <= '0;
      win_vld  <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
      gcnt <= state == S_GAP ? gcnt + 1'b1 : '0;
      if (fin) pass_cnt <= done ? '0 : pass_cnt + 1'b1;
      // rows/cols 0-1 are suppressed so a new frame never exposes the previous frame's line data
      win_vld <= xfer && row >= RW'(2) && col >= CW'(2);
    end
  // column 2 is the newest column: rows r-2, r-1, r come from line2, line1, the live pixel
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (xfer) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= l2;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= l1;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.pix_data;
    end
  line_buffer #(.DEPTH(IMG_W), .WIDTH(M)) lb1 (.clk(clk), .en(xfer), .din(bus.pix_data), .dout(l1));
  line_buffer #(.DEPTH(IMG_W), .WIDTH(M)) lb2 (.clk(clk), .en(xfer), .din(l1), .dout(l2));
  assign bus.pix_ready   = ready;
  assign bus.win_valid   = win_vld;
  assign bus.fmap_finish = fin;
  assign bus.all_done    = done;
  assign bus.pass_count  = pass_cnt;
  assign bus.P00 = win[0];
  assign bus.P01 = win[1];
  assign bus.P02 = win[2];
  assign bus.P03 = win[3];
  assign bus.P04 = win[4];
  assign bus.P05 = win[5];
  assign bus.P06 = win[6];
  assign bus.P07 = win[7];
  assign bus.P08 = win[8];
endmodule

// File: tb/tb_conv_window_g.sv
// tb_conv_window_g: directed 5x5 frames checking windows, gap, pass counting and mid-frame reset
module tb_conv_window_g;
  localparam int W = 5, H = 5, GP = 4, NP = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0, nerr = 0, nfin = 0, fin_at = 0, ndone = 0, spur = 0;
  int gz, nf0;
  logic [71:0] wins[$];
  conv_window_g_if #(.M(8)) bus();
  conv_window_g #(.M(8), .IMG_W(W), .IMG_H(H), .NPASS(NP), .GAP(GP)) dut (
    .clk(clk), .Rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [71:0] cur_win();
    return {bus.P00, bus.P01, bus.P02, bus.P03, bus.P04, bus.P05, bus.P06, bus.P07, bus.P08};
  endfunction
  function automatic logic [71:0] exp_win(input int base, input int k);
    logic [71:0] w;
    int r, c;
    r = 2 + k / 3;
    c = 2 + k % 3;
    for (int j = 0; j < 9; j++) w[71-8*j -: 8] = 8'(base + (r - 2 + j / 3) * W + (c - 2 + j % 3));
    return w;
  endfunction
  function automatic int bad_wins(input int base);
    int b = 0;
    for (int k = 0; k < wins.size(); k++) if (wins[k] !== exp_win(base, k)) b++;
    return b;
  endfunction
  function automatic logic [71:0] win_at(input int k);
    return wins.size() > k ? wins[k] : '0;
  endfunction
  task automatic step(input logic v, input logic [7:0] d);
    bus.pix_valid = v;
    bus.pix_data  = d;
    @(posedge clk);
    #1;
    if (bus.win_valid) wins.push_back(cur_win());
    if (!v && bus.win_valid) spur++;
    if (bus.fmap_finish) begin
      nfin++;
      fin_at = wins.size();
    end
    if (bus.all_done) ndone++;
  endtask
  task automatic frame(input int base, input bit tog);
    int i = 0, g = 0;
    bit ph = 0, rdy;
    wins.delete();
    while (i < W * H && g < 400) begin
      g++;
      if (tog && ph) step(1'b0, 8'h55);
      else begin
        rdy = bus.pix_ready;
        step(1'b1, 8'(base + i));
        if (rdy) i++;
      end
      ph = !ph;
    end
    chk("frame_len", i, W * H);
  endtask
  task automatic gap(output int n);
    int g = 0;
    n = 0;
    while (!bus.pix_ready && g < 20) begin
      g++;
      n++;
      step(1'b1, 8'hEE);
    end
  endtask
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    #12;
    chk("rst_ready", bus.pix_ready, 1);
    chk("rst_wv", bus.win_valid, 0);
    chk("rst_win", cur_win(), 0);
    chk("rst_fin", bus.fmap_finish, 0);
    chk("rst_pass", bus.pass_count, 0);
    chk("rst_done", bus.all_done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0, 1'b0);
    chk("f1_nwin", wins.size(), 9);
    chk("f1_first", win_at(0), 72'h00_01_02_05_06_07_0A_0B_0C);
    chk("f1_last", win_at(8), 72'h0C_0D_0E_11_12_13_16_17_18);
    chk("f1_fin_at", fin_at, 9);
    chk("f1_nfin", nfin, 1);
    gap(gz);
    chk("f1_gap", gz, GP + 1);
    chk("f1_gap_nowin", wins.size(), 9);
    chk("f1_pass", bus.pass_count, 1);
    frame(100, 1'b0);
    chk("f2_nwin", wins.size(), 9);
    chk("f2_first", win_at(0), 72'h64_65_66_69_6A_6B_6E_6F_70);
    chk("f2_wins", bad_wins(100), 0);
    gap(gz);
    chk("f2_gap", gz, GP + 1);
    chk("f2_pass", bus.pass_count, 2);
    frame(0, 1'b1);
    chk("f3_nwin", wins.size(), 9);
    chk("f3_wins", bad_wins(0), 0);
    chk("f3_spur", spur, 0);
    chk("f3_fin_at", fin_at, 9);
    gap(gz);
    chk("f3_pass", bus.pass_count, 3);
    for (int k = 4; k <= 8; k++) begin
      frame(k * 10, 1'b0);
      if (k == 7) chk("done_early", ndone, 0);
      gap(gz);
      chk("pass_k", bus.pass_count, k % NP);
    end
    chk("done_once", ndone, 1);
    chk("nfin8", nfin, 8);
    frame(30, 1'b0);
    gap(gz);
    chk("f9_pass", bus.pass_count, 1);
    wins.delete();
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
    chk("pre_rst_wv", bus.win_valid, 1);
    nf0 = nfin;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wv", bus.win_valid, 0);
    chk("mid_rst_win", cur_win(), 0);
    chk("mid_rst_ready", bus.pix_ready, 1);
    chk("mid_rst_pass", bus.pass_count, 0);
    chk("mid_rst_fin", bus.fmap_finish, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(50, 1'b0);
    chk("f11_nwin", wins.size(), 9);
    chk("f11_wins", bad_wins(50), 0);
    chk("f11_nfin", nfin, nf0 + 1);
    chk("f11_fin_at", fin_at, 9);
    gap(gz);
    chk("f11_pass", bus.pass_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
